// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns level load/store commands from the instruction unit into a
// single registered read/write request to the system memory subsystem, waits for
// mem_resp (or a timeout) and returns a one-cycle done pulse with an error flag.
// Optional byte-lane steering is enabled by defining MIU_BYTE_LANE_EN.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned OPND_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load,
    input  logic                       store,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [OPND_W-1:0]          rdata,
    output logic                       done,
    output logic                       err,
    output logic                       cs,
    output logic                       read_req,
    output logic                       write_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/OPND_W-1:0]   byte_en,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_resp
);

    localparam int unsigned LANES = DATA_W / OPND_W;
    // Last counter value before the request is abandoned
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone, StRelease} state_e;

    state_e state_q, state_d;

    logic [OPND_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              read_req_q, read_req_d;
    logic              write_req_q, write_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LANES-1:0]  byte_en_q, byte_en_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [DATA_W-1:0] store_wdata;
    logic [LANES-1:0]  store_be;
    logic [OPND_W-1:0] rd_lane;

`ifdef MIU_BYTE_LANE_EN
    // Lane steering: low operand replicated on writes, lane chosen by address bit 0
    always_comb begin
        store_wdata          = {LANES{wdata[OPND_W-1:0]}};
        store_be             = '0;
        store_be[addr[0]]    = 1'b1;
        rd_lane              = mem_addr_q[0] ? mem_rdata[OPND_W +: OPND_W]
                                             : mem_rdata[OPND_W-1:0];
    end
`else
    assign store_wdata = wdata;
    assign store_be    = '1;
    assign rd_lane     = mem_rdata[OPND_W-1:0];

    // Upper read lane only matters when lane steering is built in
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^mem_rdata[DATA_W-1:OPND_W];
`endif

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; RELEASE blocks a held command from retriggering
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (load || store) state_d = StAccess;
            StAccess:  if (mem_resp || (cnt_q == TO_LAST)) state_d = StDone;
            StDone:    state_d = StRelease;
            StRelease: if (!load && !store) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and timeout counter
    always_comb begin
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        read_req_d  = read_req_q;
        write_req_d = write_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        byte_en_d   = byte_en_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Load has priority; a simultaneous store is dropped
                if (load) begin
                    read_req_d = 1'b1;
                    mem_addr_d = addr;
                end else if (store) begin
                    write_req_d = 1'b1;
                    mem_addr_d  = addr;
                    mem_wdata_d = store_wdata;
                    byte_en_d   = store_be;
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 8'd1;
                // A response on the timeout cycle still counts as success
                if (mem_resp) begin
                    read_req_d  = 1'b0;
                    write_req_d = 1'b0;
                    done_d      = 1'b1;
                    if (read_req_q) rdata_d = rd_lane;
                end else if (cnt_q == TO_LAST) begin
                    read_req_d  = 1'b0;
                    write_req_d = 1'b0;
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            read_req_q  <= 1'b0;
            write_req_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            byte_en_q   <= '0;
            cnt_q       <= '0;
        end else begin
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            read_req_q  <= read_req_d;
            write_req_q <= write_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            byte_en_q   <= byte_en_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign read_req  = read_req_q;
    assign write_req = write_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign byte_en   = byte_en_q;
    assign cs        = read_req_q | write_req_q;

endmodule
